// File: rtl/cpu_run_pkg.sv
// rtl/cpu_run_pkg.sv - shared state encoding and index-width helper for the run controller
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_TMO  = 3'd4
  } run_state_e;

  // Index width for an N-entry bank; never narrower than one bit
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpu_run_argbank.sv
// rtl/cpu_run_argbank.sv - write-gated register bank with flat output, used for arguments and results
module cpu_run_argbank
  import cpu_run_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   we,
  input  logic [N*W-1:0] wdata,
  output logic [N*W-1:0] q
);

  logic [N*W-1:0] bank_q;
  logic [N*W-1:0] bank_d;

  // Each word takes its slice of wdata when its enable is set, otherwise holds
  always_comb begin
    bank_d = bank_q;
    for (int i = 0; i < N; i++) begin
      if (we[i]) begin
        bank_d[i*W +: W] = wdata[i*W +: W];
      end
    end
  end

  // Bank storage, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q <= '0;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign q = bank_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run controller FSM: core reset sequence, argument bank, result capture; CPU_RUN_CYCLE_COUNT_EN adds cycle counter and timeout
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NUM_ARGS       = 2,
  parameter int NUM_RES        = 2,
  parameter int RST_CYCLES     = 2,
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        arg_we,
  input  logic [idx_w(NUM_ARGS)-1:0]  arg_idx,
  input  logic [XLEN-1:0]             arg_data,
  input  logic [idx_w(NUM_RES)-1:0]   res_idx,
  output logic [XLEN-1:0]             res_data,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout,
  output logic [CNT_W-1:0]            cycle_count,
  output logic                        core_reset,
  output logic                        core_started,
  output logic [NUM_ARGS*XLEN-1:0]    core_args,
  input  logic                        core_done,
  input  logic [NUM_RES*XLEN-1:0]     core_result
);

`ifdef CPU_RUN_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam int               HOLD_W    = idx_w(RST_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  run_state_e          state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic                busy_q, busy_d;
  logic                core_reset_q, core_reset_d;
  logic                core_started_q, core_started_d;
  logic                res_we;
  logic [NUM_ARGS-1:0] arg_wmask;
  logic [NUM_RES*XLEN-1:0] res_flat;

  // Next state, counters and the output decode of the state being entered
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    res_we    = 1'b0;
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    if (abort) begin
      state_d   = ST_IDLE;
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_TMO: begin
          if (start) begin
            state_d   = ST_HOLD;
            hold_d    = '0;
            cnt_d     = '0;
            done_d    = 1'b0;
            timeout_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_RUN;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (CNT_EN) begin
            cnt_d = cnt_inc;
          end
          // core_done takes priority over a timeout landing on the same cycle
          if (core_done) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            res_we  = 1'b1;
          end else if (CNT_EN && (cnt_inc >= TMO_LIMIT)) begin
            state_d   = ST_TMO;
            timeout_d = 1'b1;
            res_we    = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d         = (state_d == ST_HOLD) || (state_d == ST_RUN);
    core_started_d = (state_d == ST_RUN);
    core_reset_d   = !core_started_d;
  end

  // State and registered outputs; the core is held in reset out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      hold_q         <= '0;
      cnt_q          <= '0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
      core_started_q <= 1'b0;
      core_reset_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      cnt_q          <= cnt_d;
      done_q         <= done_d;
      timeout_q      <= timeout_d;
      busy_q         <= busy_d;
      core_started_q <= core_started_d;
      core_reset_q   <= core_reset_d;
    end
  end

  // Host argument writes land only while idle and only for an existing index
  always_comb begin
    arg_wmask = '0;
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (arg_we && !busy_q && (int'(arg_idx) == i)) begin
        arg_wmask[i] = 1'b1;
      end
    end
  end

  cpu_run_argbank #(.N(NUM_ARGS), .W(XLEN)) u_args (
    .clk   (clk),
    .reset (reset),
    .we    (arg_wmask),
    .wdata ({NUM_ARGS{arg_data}}),
    .q     (core_args)
  );

  cpu_run_argbank #(.N(NUM_RES), .W(XLEN)) u_res (
    .clk   (clk),
    .reset (reset),
    .we    ({NUM_RES{res_we}}),
    .wdata (core_result),
    .q     (res_flat)
  );

  // Result read mux; an index past the bank reads as zero
  always_comb begin
    res_data = '0;
    for (int i = 0; i < NUM_RES; i++) begin
      if (int'(res_idx) == i) begin
        res_data = res_flat[i*XLEN +: XLEN];
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign cycle_count  = cnt_q;
  assign core_reset   = core_reset_q;
  assign core_started = core_started_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - scoreboard bench for cpu_run_ctrl; follows CPU_RUN_CYCLE_COUNT_EN when defined
module tb_cpu_run_ctrl;
  import cpu_run_pkg::*;

  localparam int XLEN  = 32;
  localparam int NA    = 2;
  localparam int NR    = 2;
  localparam int CW    = 24;
  localparam int TMO   = 100;
  localparam int LIMIT = 130;
  localparam int AW    = idx_w(NA);
  localparam int RW    = idx_w(NR);
`ifdef CPU_RUN_CYCLE_COUNT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, arg_we = 1'b0;
  logic [AW-1:0] arg_idx = '0;
  logic [XLEN-1:0] arg_data = '0;
  logic [RW-1:0] res_idx = '0;
  logic [XLEN-1:0] res_data;
  logic busy, done, timeout, core_reset, core_started;
  logic [CW-1:0] cycle_count;
  logic [NA*XLEN-1:0] core_args;
  logic core_done = 1'b0;
  logic [NR*XLEN-1:0] core_result = '0;

  cpu_run_ctrl #(.XLEN(XLEN), .NUM_ARGS(NA), .NUM_RES(NR), .RST_CYCLES(2),
                 .CNT_W(CW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .arg_we(arg_we), .arg_idx(arg_idx), .arg_data(arg_data),
    .res_idx(res_idx), .res_data(res_data),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count),
    .core_reset(core_reset), .core_started(core_started), .core_args(core_args),
    .core_done(core_done), .core_result(core_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              done;
    logic              tmo;
    logic              chk_cnt;
    logic [CW-1:0]     cnt;
    logic [NR*XLEN-1:0] res;
    logic [NA*XLEN-1:0] args;
  } exp_t;

  exp_t exp_q[$];
  logic [NA*XLEN-1:0] m_args = '0;
  logic [NR*XLEN-1:0] m_res  = '0;
  int n_cmp = 0;
  int n_bad = 0;
  logic rst_seen = 1'b0;

  always @(posedge clk) rst_seen <= reset;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: reset-state checks, and a scoreboard pop whenever a run ends
  initial begin : monitor
    logic prev_busy, got_run, moved;
    int hold_n;
    logic [NA*XLEN-1:0] seen;
    exp_t e;
    prev_busy = 1'b0; got_run = 1'b0; moved = 1'b0; hold_n = 0; seen = '0;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        chk("rst_core_reset", core_reset, 1);
        chk("rst_core_started", core_started, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_core_args", core_args, 0);
        for (int i = 0; i < NR; i++) begin
          res_idx = RW'(i); #1;
          chk($sformatf("rst_res%0d", i), res_data, 0);
        end
      end
      if (busy && !prev_busy) begin
        hold_n = 0; got_run = 1'b0; moved = 1'b0; seen = '0;
      end
      if (busy && core_reset) hold_n++;
      if (busy && core_started) begin
        if (!got_run) begin
          seen = core_args; got_run = 1'b1;
        end else if (core_args !== seen) begin
          moved = 1'b1;
        end
      end
      if (!busy && prev_busy) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL run_end: run ended with no queued expectation");
        end else begin
          e = exp_q.pop_front();
          chk("done", done, e.done);
          chk("timeout", timeout, e.tmo);
          if (e.chk_cnt) chk("cycle_count", cycle_count, e.cnt);
          chk("core_reset_after", core_reset, 1);
          chk("core_started_after", core_started, 0);
          chk("hold_cycles", hold_n, 2);
          chk("reached_run", got_run, 1);
          chk("args_seen", seen, e.args);
          chk("args_stable", moved, 0);
          for (int i = 0; i < NR; i++) begin
            res_idx = RW'(i); #1;
            chk($sformatf("res%0d", i), res_data, e.res[i*XLEN +: XLEN]);
          end
        end
      end
      prev_busy = busy;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_arg(input int idx, input logic [XLEN-1:0] d);
    arg_we = 1'b1; arg_idx = AW'(idx); arg_data = d;
    step();
    arg_we = 1'b0;
    if (idx < NA) m_args[idx*XLEN +: XLEN] = d;
  endtask

  // One run: dcy = RUN cycle carrying core_done, abort_at / rst_at = RUN cycle of abort / reset (0 = never)
  task automatic do_run(input int dcy, input int abort_at, input int rst_at, input bit wr,
                        input int widx, input logic [XLEN-1:0] wdat, input logic [NR*XLEN-1:0] rv);
    exp_t e;
    bit ok;
    int t_d, t_t, t_a, t_r, t_end;
    t_d = (dcy > 0) ? dcy : 9999;
    t_t = EN ? TMO : 9999;
    t_a = (abort_at > 0) ? abort_at : 9999;
    t_r = (rst_at > 0) ? rst_at : 9999;
    t_end = t_d;
    if (t_t < t_end) t_end = t_t;
    if (t_a < t_end) t_end = t_a;
    if (t_r < t_end) t_end = t_r;
    if (wr && widx < NA) m_args[widx*XLEN +: XLEN] = wdat;
    core_result = rv;
    e.args = m_args; e.done = 1'b0; e.tmo = 1'b0; e.chk_cnt = 1'b1; e.cnt = '0; e.res = m_res;
    if (t_end >= LIMIT) begin
      e.chk_cnt = !EN;
    end else if (t_r == t_end) begin
      e.res = '0;
    end else if (t_a == t_end) begin
      e.chk_cnt = !EN;
    end else if (t_d == t_end) begin
      e.done = 1'b1; e.cnt = EN ? CW'(dcy) : '0; e.res = rv;
    end else begin
      e.tmo = 1'b1; e.cnt = CW'(TMO); e.res = rv;
    end
    exp_q.push_back(e);

    start = 1'b1;
    if (wr) begin
      arg_we = 1'b1; arg_idx = AW'(widx); arg_data = wdat;
    end
    step();
    start = 1'b0; arg_we = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (core_started) begin ok = 1'b1; break; end
      step();
    end
    chk("run_entered", ok, 1);

    for (int c = 1; c <= LIMIT; c++) begin
      core_done = (c == dcy);
      abort     = (c == abort_at);
      reset     = (c == rst_at);
      start     = ($urandom_range(0, 7) == 0);
      if (c == 1) begin
        arg_we = 1'b1; arg_idx = '0; arg_data = 32'd99;
      end else if ($urandom_range(0, 7) == 0) begin
        arg_we = 1'b1; arg_idx = AW'($urandom_range(0, NA - 1)); arg_data = $urandom;
      end
      step();
      core_done = 1'b0; abort = 1'b0; reset = 1'b0; start = 1'b0; arg_we = 1'b0;
      if (!busy) break;
    end
    if (t_end >= LIMIT) chk("busy_past_limit", busy, 1);
    else chk("run_exit_busy", busy, 0);
    if (busy) begin
      abort = 1'b1; step(); abort = 1'b0;
    end
    m_res = e.res;
    if (t_r == t_end && t_end < LIMIT) m_args = '0;
    step(); step();
  endtask

  initial begin : stim
    int mode;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    write_arg(0, 32'd10);
    write_arg(1, 32'd7);
    do_run(40, 0, 0, 1'b0, 0, '0, {32'd0, 32'd55});
    do_run(25, 0, 0, 1'b1, 1, 32'd5, {$urandom, $urandom});
    do_run(0, 0, 0, 1'b0, 0, '0, {$urandom, $urandom});
    do_run(0, 20, 0, 1'b0, 0, '0, {$urandom, $urandom});
    do_run(30, 0, 0, 1'b0, 0, '0, {$urandom, $urandom});
    do_run(100, 0, 0, 1'b0, 0, '0, {$urandom, $urandom});
    do_run(0, 0, 30, 1'b0, 0, '0, {$urandom, $urandom});

    for (int r = 0; r < 12; r++) begin
      write_arg($urandom_range(0, NA - 1), $urandom);
      mode = $urandom_range(0, 5);
      if (mode == 0)
        do_run($urandom_range(30, 120), $urandom_range(1, 29), 0, $urandom_range(0, 1),
               $urandom_range(0, NA - 1), $urandom, {$urandom, $urandom});
      else if (mode == 1)
        do_run(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, NA - 1), $urandom,
               {$urandom, $urandom});
      else
        do_run($urandom_range(1, 120), 0, 0, $urandom_range(0, 1), $urandom_range(0, NA - 1),
               $urandom, {$urandom, $urandom});
    end

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
